// File: rtl/click_decoder.sv
// Groups debounced press pulses that fall within an inter-click window and
// reports each group as a single, double or triple click event.
module click_decoder #(
  parameter int WINDOW_CNT = 30_000_000,
  parameter int TIMER_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pulse,
  output logic       click_single,
  output logic       click_double,
  output logic       click_triple,
  output logic [1:0] last_clicks,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WINDOW = 2'b01
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(WINDOW_CNT - 1);

  state_t             state;
  logic [1:0]         cnt;
  logic [TIMER_W-1:0] timer;

  // A press always beats a timeout on the same edge, so no press is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      timer        <= '0;
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
      last_clicks  <= 2'd0;
      busy         <= 1'b0;
    end else begin
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_pulse) begin
            state <= WINDOW;
            cnt   <= 2'd1;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        WINDOW: begin
          if (cnt == 2'd0 || cnt == 2'd3) begin
            state <= IDLE;
            cnt   <= 2'd0;
            timer <= '0;
            busy  <= 1'b0;
          end else if (btn_pulse) begin
            if (cnt == 2'd2) begin
              click_triple <= 1'b1;
              last_clicks  <= 2'd3;
              state        <= IDLE;
              cnt          <= 2'd0;
              timer        <= '0;
              busy         <= 1'b0;
            end else begin
              cnt   <= cnt + 2'd1;
              timer <= '0;
            end
          end else if (timer == TIMER_MAX) begin
            click_single <= (cnt == 2'd1);
            click_double <= (cnt == 2'd2);
            last_clicks  <= cnt;
            state        <= IDLE;
            cnt          <= 2'd0;
            timer        <= '0;
            busy         <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_click_decoder.sv
// Directed and randomized checks of click_decoder with a 10-cycle window.
module tb_click_decoder;

  localparam int WC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pulse = 1'b0;
  logic       click_single, click_double, click_triple, busy;
  logic [1:0] last_clicks;
  logic [5:0] obs;

  int checks = 0;
  int fails  = 0;

  click_decoder #(.WINDOW_CNT(WC), .TIMER_W(4)) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse),
    .click_single(click_single), .click_double(click_double),
    .click_triple(click_triple), .last_clicks(last_clicks), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observation vector: {single, double, triple, last_clicks, busy}
  assign obs = {click_single, click_double, click_triple, last_clicks, busy};

  task automatic step(input logic p, input logic r);
    btn_pulse = p;
    rst       = r;
    @(posedge clk);
    #1;
    btn_pulse = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1);
    checks++;
    if (obs !== 6'b000_00_0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs, 6'b000_00_0);
    end
    step(1'b0, 1'b1);
    checks++;
    if (obs !== 6'b000_00_0) begin
      fails++;
      $display("[TB] FAIL reset_hold: got %b expected %b", obs, 6'b000_00_0);
    end
  endtask

  task automatic test_single;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < WC; i++) begin
      checks++;
      if (obs !== 6'b000_00_1) begin
        fails++;
        $display("[TB] FAIL single_open[%0d]: got %b expected %b", i, obs, 6'b000_00_1);
      end
      step(1'b0, 1'b0);
    end
    checks++;
    if (obs !== 6'b100_01_0) begin
      fails++;
      $display("[TB] FAIL single_event: got %b expected %b", obs, 6'b100_01_0);
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b000_01_0) begin
      fails++;
      $display("[TB] FAIL single_after: got %b expected %b", obs, 6'b000_01_0);
    end
  endtask

  task automatic test_double;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b000_00_1) begin
      fails++;
      $display("[TB] FAIL double_gap: got %b expected %b", obs, 6'b000_00_1);
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < WC - 1; i++) begin
      checks++;
      if (obs !== 6'b000_00_1) begin
        fails++;
        $display("[TB] FAIL double_open[%0d]: got %b expected %b", i, obs, 6'b000_00_1);
      end
      step(1'b0, 1'b0);
    end
    checks++;
    if (obs !== 6'b000_00_1) begin
      fails++;
      $display("[TB] FAIL double_pre: got %b expected %b", obs, 6'b000_00_1);
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b010_10_0) begin
      fails++;
      $display("[TB] FAIL double_event: got %b expected %b", obs, 6'b010_10_0);
    end
  endtask

  task automatic test_triple;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 6'b000_00_1) begin
      fails++;
      $display("[TB] FAIL triple_two: got %b expected %b", obs, 6'b000_00_1);
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 6'b001_11_0) begin
      fails++;
      $display("[TB] FAIL triple_event: got %b expected %b", obs, 6'b001_11_0);
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 6'b000_11_1) begin
      fails++;
      $display("[TB] FAIL fourth_opens: got %b expected %b", obs, 6'b000_11_1);
    end
    for (int i = 0; i < WC - 1; i++) step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b000_11_1) begin
      fails++;
      $display("[TB] FAIL fourth_pre: got %b expected %b", obs, 6'b000_11_1);
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b100_01_0) begin
      fails++;
      $display("[TB] FAIL fourth_single: got %b expected %b", obs, 6'b100_01_0);
    end
  endtask

  task automatic test_boundary;
    // Second press lands exactly on the timeout edge
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < WC - 1; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 6'b000_00_1) begin
      fails++;
      $display("[TB] FAIL edge_press_wins: got %b expected %b", obs, 6'b000_00_1);
    end
    for (int i = 0; i < WC - 1; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b010_10_0) begin
      fails++;
      $display("[TB] FAIL edge_double: got %b expected %b", obs, 6'b010_10_0);
    end
    // Second press one edge after the timeout
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < WC - 1; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b100_01_0) begin
      fails++;
      $display("[TB] FAIL late_first_single: got %b expected %b", obs, 6'b100_01_0);
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 6'b000_01_1) begin
      fails++;
      $display("[TB] FAIL late_reopen: got %b expected %b", obs, 6'b000_01_1);
    end
    for (int i = 0; i < WC - 1; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b100_01_0) begin
      fails++;
      $display("[TB] FAIL late_second_single: got %b expected %b", obs, 6'b100_01_0);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b000_00_1) begin
      fails++;
      $display("[TB] FAIL mid_open: got %b expected %b", obs, 6'b000_00_1);
    end
    step(1'b1, 1'b1);
    checks++;
    if (obs !== 6'b000_00_0) begin
      fails++;
      $display("[TB] FAIL mid_reset: got %b expected %b", obs, 6'b000_00_0);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs !== 6'b000_00_1) begin
      fails++;
      $display("[TB] FAIL mid_reopen: got %b expected %b", obs, 6'b000_00_1);
    end
    for (int i = 0; i < WC - 1; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== 6'b100_01_0) begin
      fails++;
      $display("[TB] FAIL mid_single: got %b expected %b", obs, 6'b100_01_0);
    end
  endtask

  task automatic test_random;
    logic       open, es, ed, et, p;
    logic [1:0] mcnt, mlast;
    int         age, pulses, weight;
    logic [5:0] exp;
    step(1'b0, 1'b1);
    open = 1'b0; mcnt = 2'd0; mlast = 2'd0; age = 0; pulses = 0; weight = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n < 2960)
        p = ((n / 200) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      else
        p = 1'b0;
      step(p, 1'b0);
      es = 1'b0; ed = 1'b0; et = 1'b0;
      if (p) pulses++;
      // Reference: age counts edges since the latest press of the open group
      if (!open) begin
        if (p) begin open = 1'b1; mcnt = 2'd1; age = 0; end
      end else if (p) begin
        if (mcnt == 2'd2) begin
          et = 1'b1; mlast = 2'd3; open = 1'b0; mcnt = 2'd0;
        end else begin
          mcnt = mcnt + 2'd1; age = 0;
        end
      end else begin
        age++;
        if (age == WC) begin
          es = (mcnt == 2'd1); ed = (mcnt == 2'd2);
          mlast = mcnt; open = 1'b0; mcnt = 2'd0;
        end
      end
      exp = {es, ed, et, mlast, open};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL random[%0d]: got %b expected %b", n, obs, exp);
      end
      if (int'(click_single) + int'(click_double) + int'(click_triple) > 1) begin
        fails++;
        $display("[TB] FAIL exclusive[%0d]: got %b expected at most one event", n, obs);
      end
      checks++;
      weight += int'(click_single) + 2 * int'(click_double) + 3 * int'(click_triple);
    end
    checks++;
    if (weight !== pulses) begin
      fails++;
      $display("[TB] FAIL conservation: got %0d expected %0d", weight, pulses);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_double;
    test_triple;
    test_boundary;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
